tetris_move_scheduler: RTL
==========================

// Module: tetris_move_scheduler
// PURPOSE
//  Sequences piece-movement commands into the Tetris game FSM/tracker datapath.
//  Merges the gravity timer and four button inputs into one move_t stream on a
//  valid/ready handshake, one move in flight at a time.
//  Holds off between moves so the 5x5 frame tracker can finish each update.
// PARAMETERS
//  GRAV_BASE  24'd12_500_000  gravity period at level 0, in clk cycles
//  GRAV_STEP  24'd500_000     period reduction per level
//  GRAV_MIN   24'd1_000_000   floor on the gravity period
//  LOCK_CYC   4               holdoff cycles after each accepted move (>=1)
//  DAS_DELAY  24'd4_000_000   auto-repeat initial delay (AUTO_REPEAT_EN only)
//  DAS_RATE   24'd1_000_000   auto-repeat interval (AUTO_REPEAT_EN only)
// PORTS
//  clk         in   1   clock
//  rst         in   1   reset, asynchronous, active-high
//  en          in   1   game active; 0 = scheduler idle and flushed
//  right       in   1   synchronized button level
//  left        in   1   synchronized button level
//  rr          in   1   synchronized button level, rotate right
//  rl          in   1   synchronized button level, rotate left
//  level       in   4   game level; selects gravity period
//  move_ready  in   1   game FSM accepts the offered move
//  move_valid  out  1   move is offered
//  move        out  3   move_t command (DOWN/RIGHT/LEFT/ROR/ROL)
// BEHAVIOUR
//  Reset: move_valid=0, move=DOWN, state=IDLE, all pending bits=0,
//  gravity counter=0, button history=0, holdoff counter=0.
//  Edges: each button has a registered previous value; a 0->1 edge sets its
//   pending bit. If an edge and an acceptance of the same move fall in one
//   cycle, the set wins.
//  Gravity: P = max(GRAV_BASE - level*GRAV_STEP, GRAV_MIN). Subtraction
//   saturates and never wraps below 0. While en=1 the counter counts up.
//   At cnt==P-1, cnt returns to 0 and grav_pend is set. grav_pend holds a
//   single request, so extra ticks are dropped.
//   A level change applies immediately: if cnt>=P-1, the tick fires that cycle.
//  Priority, fixed: gravity DOWN > RIGHT > LEFT > ROR > ROL.
//  FSM:
//   IDLE    en=0. valid=0; pendings, cnt and holdoff cleared. -> ARM when en=1.
//   ARM     No offer. When any pending bit is set, register the winner into
//           move and assert move_valid next cycle. -> OFFER.
//   OFFER   valid=1; move is stable until move_valid&move_ready.
//           On accept: clear that pending bit, valid=0 next cycle. -> HOLD.
//   HOLD    Count LOCK_CYC cycles. -> ARM.
//   en=0 in any state: -> IDLE next cycle. valid drops and pendings clear
//   (no stale moves after re-enable).
//  Latency: pending set at cycle t -> move_valid at t+1 (ARM state).
//   Back-to-back accepted moves are spaced exactly LOCK_CYC+2 cycles.
//  Buttons and gravity keep latching during OFFER and HOLD; nothing is lost
//   except duplicate presses of an already-pending move.
//  Reset asserted mid-operation returns every output to its reset value at once.
// CONFIGURATION
//  AUTO_REPEAT_EN defined: for LEFT/RIGHT held continuously, after DAS_DELAY
//   cycles the pending bit re-sets, then every DAS_RATE cycles while held.
//   Release clears the repeat timer. Rotations never repeat.
//  AUTO_REPEAT_EN undefined: edges only; no DAS logic or timers are built.
// TESTING (GRAV_BASE=20, GRAV_STEP=4, GRAV_MIN=6, LOCK_CYC=2)
//  1 rst, en=1, level=0, ready=1, no buttons -> DOWN accepted every 20 cycles.
//  2 level=3 -> period 8; level=5 -> 20-20<6, so period 6 (floor).
//    Change level 3->0 mid-count -> no early tick.
//  3 ready=0 while DOWN offered; press left -> move stays DOWN and valid stays 1.
//    Raise ready -> DOWN accepted; LEFT offered exactly 4 cycles later.
//  4 right and rr edges in the same cycle -> RIGHT offered first, then ROR
//    after holdoff; exactly 2 moves.
//  5 hold left for 200 cycles -> exactly one LEFT without the macro.
//    With AUTO_REPEAT_EN, DAS_DELAY=50, DAS_RATE=20 -> LEFT at the press,
//    then at +50, +70, ...
//  6 drop en during OFFER with pending rl -> valid=0 next cycle.
//    Re-enable -> no move until a new tick or press; rst mid-HOLD -> reset values.

Source files
------------

// File: rtl/tetris_move_scheduler.sv
// Merges gravity ticks and button edges into one valid/ready move stream with a post-move holdoff.
// Optional LEFT/RIGHT auto-repeat is built only when AUTO_REPEAT_EN is defined.
module tetris_move_scheduler #(
  parameter logic [23:0] GRAV_BASE = 24'd12_500_000,
  parameter logic [23:0] GRAV_STEP = 24'd500_000,
  parameter logic [23:0] GRAV_MIN  = 24'd1_000_000,
`ifdef AUTO_REPEAT_EN
  parameter logic [23:0] DAS_DELAY = 24'd4_000_000,
  parameter logic [23:0] DAS_RATE  = 24'd1_000_000,
`endif
  parameter int unsigned LOCK_CYC  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       right,
  input  logic       left,
  input  logic       rr,
  input  logic       rl,
  input  logic [3:0] level,
  input  logic       move_ready,
  output logic       move_valid,
  output logic [2:0] move
);

  // Move codes double as pending-bit indices.
  typedef enum logic [2:0] {
    MvDown  = 3'd0,
    MvRight = 3'd1,
    MvLeft  = 3'd2,
    MvRor   = 3'd3,
    MvRol   = 3'd4
  } move_t;

  typedef enum logic [1:0] {StIdle, StArm, StOffer, StHold} state_t;

  localparam int unsigned HoldW = (LOCK_CYC > 1) ? $clog2(LOCK_CYC) : 1;
  localparam logic [HoldW-1:0] HoldLast = HoldW'(LOCK_CYC - 1);

  state_t           state_q, state_d;
  move_t            move_q, move_d, winner;
  logic             valid_q, valid_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [4:0]       pend_q, pend_d, set_vec, rep_set;
  logic [3:0]       btn_now, btn_q, btn_edge;
  logic [23:0]      cnt_q, cnt_d, grav_raw, period;
  logic [27:0]      lvl_prod;
  logic             tick, accept;

  assign btn_now  = {rl, rr, left, right};
  assign btn_edge = btn_now & ~btn_q;

  // Gravity period with saturating subtraction and a floor.
  assign lvl_prod = 28'(level) * 28'(GRAV_STEP);
  assign grav_raw = (lvl_prod >= 28'(GRAV_BASE)) ? 24'd0 : (GRAV_BASE - lvl_prod[23:0]);
  assign period   = (grav_raw < GRAV_MIN) ? GRAV_MIN : grav_raw;
  // >= so that a level change shortening the period below cnt fires at once.
  assign tick     = en && (({1'b0, cnt_q} + 25'd1) >= {1'b0, period});

  always_comb begin
    cnt_d = cnt_q + 24'd1;
    if (!en || tick) begin
      cnt_d = '0;
    end
  end

`ifdef AUTO_REPEAT_EN
  logic [23:0] das_cnt_q [2];
  logic [23:0] das_cnt_d [2];
  logic [1:0]  das_arm_q, das_arm_d, das_fire;

  // Index 0 is RIGHT, 1 is LEFT; the timer counts cycles held since the last set.
  always_comb begin
    das_arm_d = das_arm_q;
    das_fire  = 2'b00;
    for (int i = 0; i < 2; i++) begin
      das_cnt_d[i] = das_cnt_q[i] + 24'd1;
      if (!en || !btn_now[i] || !btn_q[i]) begin
        das_cnt_d[i] = '0;
        das_arm_d[i] = 1'b0;
      end else if (das_cnt_q[i] == ((das_arm_q[i] ? DAS_RATE : DAS_DELAY) - 24'd1)) begin
        das_fire[i]  = 1'b1;
        das_cnt_d[i] = '0;
        das_arm_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      das_cnt_q[0] <= '0;
      das_cnt_q[1] <= '0;
      das_arm_q    <= '0;
    end else begin
      das_cnt_q[0] <= das_cnt_d[0];
      das_cnt_q[1] <= das_cnt_d[1];
      das_arm_q    <= das_arm_d;
    end
  end

  assign rep_set = {2'b00, das_fire, 1'b0};
`else
  assign rep_set = '0;
`endif

  assign set_vec = {btn_edge, tick} | rep_set;
  assign accept  = (state_q == StOffer) && valid_q && move_ready;

  // Set wins over a same-cycle clear of the same move.
  always_comb begin
    pend_d = pend_q;
    if (accept) begin
      pend_d[move_q] = 1'b0;
    end
    pend_d = pend_d | set_vec;
    if (!en) begin
      pend_d = '0;
    end
  end

  always_comb begin
    winner = MvDown;
    if (pend_q[0])      winner = MvDown;
    else if (pend_q[1]) winner = MvRight;
    else if (pend_q[2]) winner = MvLeft;
    else if (pend_q[3]) winner = MvRor;
    else if (pend_q[4]) winner = MvRol;
  end

  always_comb begin
    state_d = state_q;
    move_d  = move_q;
    valid_d = valid_q;
    hold_d  = hold_q;
    unique case (state_q)
      StIdle: begin
        if (en) state_d = StArm;
      end
      StArm: begin
        if (|pend_q) begin
          move_d  = winner;
          valid_d = 1'b1;
          state_d = StOffer;
        end
      end
      StOffer: begin
        if (accept) begin
          valid_d = 1'b0;
          hold_d  = '0;
          state_d = StHold;
        end
      end
      StHold: begin
        if (hold_q == HoldLast) begin
          hold_d  = '0;
          state_d = StArm;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (!en) begin
      state_d = StIdle;
      valid_d = 1'b0;
      hold_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      move_q  <= MvDown;
      valid_q <= 1'b0;
      hold_q  <= '0;
      pend_q  <= '0;
      btn_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      move_q  <= move_d;
      valid_q <= valid_d;
      hold_q  <= hold_d;
      pend_q  <= pend_d;
      btn_q   <= btn_now;
      cnt_q   <= cnt_d;
    end
  end

  assign move_valid = valid_q;
  assign move       = move_q;

endmodule
